// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm annunciator. Synchronizes the asynchronous alarm flag and
// acknowledge key, then runs a four-state FSM (IDLE/RING/ACKED/TIMEOUT) that
// drives a rotating LED pattern and a blinking buzzer while ringing, with a
// timeout after ALARM_TICKS prescaled ticks. All outputs are registered.
module alarm_ctrl #(
    parameter int TICK_DIV    = 5000000,
    parameter int ALARM_TICKS = 100,
    parameter int BLINK_TICKS = 5
) (
    input  logic       iCLK,
    input  logic       iRSTn,
    input  logic       iALARM,
    input  logic       iACKn,
    input  logic       iEN,
    output logic [9:0] oLED,
    output logic       oBUZZ,
    output logic       oACTIVE,
    output logic       oMISSED
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RING    = 2'd1;
    localparam logic [1:0] ST_ACKED   = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam logic [9:0] LED_OFF   = 10'h000;
    localparam logic [9:0] LED_FIRST = 10'h001;
    localparam logic [9:0] LED_ALL   = 10'h3FF;

    // Synchronizer and edge-detector registers
    logic          alarm_s1_q, alarm_s2_q, alarm_prev_q, alarm_rise_q;
    logic          alarm_armed_q;
    logic [1:0]    fill_q;
    logic          ack_s1_q, ack_s2_q, ack_prev_q, ack_fall_q;

    // FSM, counters and output registers
    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [9:0]    led_q, led_d;
    logic          buzz_q, buzz_d;
    logic          active_q, active_d;
    logic          missed_q, missed_d;

    logic          tick_s;
    logic          last_tick_s;
    logic          blink_tog_s;

    // Two-flop synchronizers plus registered edge detectors. The alarm edge is
    // only honoured once a genuine low level has been seen after reset (armed),
    // so an alarm still held high across reset cannot ring again by itself.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            alarm_s1_q    <= 1'b0;
            alarm_s2_q    <= 1'b0;
            alarm_prev_q  <= 1'b0;
            alarm_rise_q  <= 1'b0;
            alarm_armed_q <= 1'b0;
            fill_q        <= 2'b00;
            ack_s1_q      <= 1'b1;
            ack_s2_q      <= 1'b1;
            ack_prev_q    <= 1'b0;
            ack_fall_q    <= 1'b0;
        end else begin
            alarm_s1_q    <= iALARM;
            alarm_s2_q    <= alarm_s1_q;
            alarm_prev_q  <= alarm_s2_q;
            alarm_rise_q  <= alarm_s2_q & ~alarm_prev_q & alarm_armed_q;
            fill_q        <= {fill_q[0], 1'b1};
            alarm_armed_q <= alarm_armed_q | (fill_q[1] & ~alarm_s2_q);
            ack_s1_q      <= iACKn;
            ack_s2_q      <= ack_s1_q;
            ack_prev_q    <= ack_s2_q;
            ack_fall_q    <= ack_prev_q & ~ack_s2_q;
        end
    end

    assign tick_s      = (state_q == ST_RING) && (presc_q == PW'(TICK_DIV - 1));
    assign last_tick_s = tick_s && (tcnt_q == TW'(ALARM_TICKS - 1));
    assign blink_tog_s = tick_s && (blink_q == BW'(BLINK_TICKS - 1));

    // Next-state, counter and next-output logic; outputs are derived from the
    // next state so they become valid on the same edge as the state change.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tcnt_d  = tcnt_q;
        blink_d = blink_q;
        led_d   = led_q;
        buzz_d  = buzz_q;
        if (!iEN) begin
            state_d = ST_IDLE;
            presc_d = '0;
            tcnt_d  = '0;
            blink_d = '0;
            led_d   = LED_OFF;
            buzz_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = '0;
                    tcnt_d  = '0;
                    blink_d = '0;
                    if (alarm_rise_q) begin
                        state_d = ST_RING;
                        led_d   = LED_FIRST;
                        buzz_d  = 1'b1;
                    end else begin
                        led_d   = LED_OFF;
                        buzz_d  = 1'b0;
                    end
                end
                ST_RING: begin
                    if (ack_fall_q) begin
                        // Ack has priority over a simultaneous timeout tick.
                        state_d = ST_ACKED;
                        presc_d = '0;
                        tcnt_d  = '0;
                        blink_d = '0;
                        led_d   = LED_OFF;
                        buzz_d  = 1'b0;
                    end else if (alarm_rise_q) begin
                        // Retrigger: restart the ring from scratch.
                        presc_d = '0;
                        tcnt_d  = '0;
                        blink_d = '0;
                        led_d   = LED_FIRST;
                        buzz_d  = 1'b1;
                    end else if (last_tick_s) begin
                        state_d = ST_TIMEOUT;
                        presc_d = '0;
                        tcnt_d  = TW'(ALARM_TICKS);
                        blink_d = '0;
                        led_d   = LED_ALL;
                        buzz_d  = 1'b0;
                    end else if (tick_s) begin
                        presc_d = '0;
                        if (tcnt_q == TW'(ALARM_TICKS)) begin
                            tcnt_d = tcnt_q;
                        end else begin
                            tcnt_d = tcnt_q + TW'(1);
                        end
                        if (blink_tog_s) begin
                            blink_d = '0;
                            buzz_d  = ~buzz_q;
                        end else begin
                            blink_d = blink_q + BW'(1);
                            buzz_d  = buzz_q;
                        end
                        led_d = {led_q[8:0], led_q[9]};
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_ACKED: begin
                    presc_d = '0;
                    tcnt_d  = '0;
                    blink_d = '0;
                    led_d   = LED_OFF;
                    buzz_d  = 1'b0;
                    if (!alarm_s2_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACKED;
                    end
                end
                ST_TIMEOUT: begin
                    presc_d = '0;
                    tcnt_d  = '0;
                    blink_d = '0;
                    buzz_d  = 1'b0;
                    if (ack_fall_q) begin
                        state_d = ST_IDLE;
                        led_d   = LED_OFF;
                    end else begin
                        state_d = ST_TIMEOUT;
                        led_d   = LED_ALL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    tcnt_d  = '0;
                    blink_d = '0;
                    led_d   = LED_OFF;
                    buzz_d  = 1'b0;
                end
            endcase
        end
        active_d = (state_d == ST_RING);
        missed_d = (state_d == ST_TIMEOUT);
    end

    // State, counter and output registers.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            tcnt_q   <= '0;
            blink_q  <= '0;
            led_q    <= LED_OFF;
            buzz_q   <= 1'b0;
            active_q <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tcnt_q   <= tcnt_d;
            blink_q  <= blink_d;
            led_q    <= led_d;
            buzz_q   <= buzz_d;
            active_q <= active_d;
            missed_q <= missed_d;
        end
    end

    assign oLED    = led_q;
    assign oBUZZ   = buzz_q;
    assign oACTIVE = active_q;
    assign oMISSED = missed_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl with TICK_DIV=4, ALARM_TICKS=6, BLINK_TICKS=2.
// Vectors hold input levels, the number of rising edges to advance, and the
// outputs expected after those edges. Expectations go through a queue.
module tb_alarm_ctrl;

    logic       iCLK = 1'b0;
    logic       iRSTn;
    logic       iALARM;
    logic       iACKn;
    logic       iEN;
    logic [9:0] oLED;
    logic       oBUZZ;
    logic       oACTIVE;
    logic       oMISSED;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       alarm;
        logic       ackn;
        logic       en;
        int         wait_n;
        logic [9:0] led;
        logic       buzz;
        logic       active;
        logic       missed;
        string      name;
    } vec_t;

    typedef struct {
        logic [12:0] outs;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    alarm_ctrl #(
        .TICK_DIV   (4),
        .ALARM_TICKS(6),
        .BLINK_TICKS(2)
    ) dut (
        .iCLK   (iCLK),
        .iRSTn  (iRSTn),
        .iALARM (iALARM),
        .iACKn  (iACKn),
        .iEN    (iEN),
        .oLED   (oLED),
        .oBUZZ  (oBUZZ),
        .oACTIVE(oACTIVE),
        .oMISSED(oMISSED)
    );

    always #5 iCLK = ~iCLK;

    function automatic vec_t mk(input logic a, input logic k, input logic e,
                                input int n, input logic [9:0] led,
                                input logic bz, input logic act,
                                input logic mis, input string nm);
        vec_t v;
        v.alarm = a; v.ackn = k; v.en = e; v.wait_n = n;
        v.led = led; v.buzz = bz; v.active = act; v.missed = mis; v.name = nm;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.outs = {v.led, v.buzz, v.active, v.missed};
        e.name = v.name;
        exp_q.push_back(e);
    endtask

    task automatic check_front();
        exp_t        e;
        logic [12:0] got;
        got = {oLED, oBUZZ, oACTIVE, oMISSED};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got led=%h buzz=%b active=%b missed=%b, no expectation queued",
                     oLED, oBUZZ, oACTIVE, oMISSED);
        end else begin
            e = exp_q.pop_front();
            if (got !== e.outs) begin
                errors++;
                $display("FAIL %s: got led=%h buzz=%b active=%b missed=%b, want led=%h buzz=%b active=%b missed=%b",
                         e.name, oLED, oBUZZ, oACTIVE, oMISSED,
                         e.outs[12:3], e.outs[2], e.outs[1], e.outs[0]);
            end
        end
    endtask

    task automatic apply_vec(input vec_t v);
        @(negedge iCLK);
        iALARM = v.alarm;
        iACKn  = v.ackn;
        iEN    = v.en;
        push_exp(v);
        repeat (v.wait_n) @(posedge iCLK);
        #1;
        check_front();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRSTn  = 1'b0;
        iALARM = 1'b0;
        iACKn  = 1'b1;
        iEN    = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        push_exp(mk(0, 1, 0, 0, 10'h000, 0, 0, 0, "reset_state"));
        check_front();
        @(negedge iCLK);
        iRSTn = 1'b1;

        // Ring, rotate, blink, time out, ignore alarm in TIMEOUT, ack back to IDLE
        vecs.push_back(mk(0, 1, 1, 5,  10'h000, 0, 0, 0, "idle_enabled"));
        vecs.push_back(mk(1, 1, 1, 3,  10'h000, 0, 0, 0, "alarm_edge3"));
        vecs.push_back(mk(1, 1, 1, 1,  10'h001, 1, 1, 0, "ring_entry_edge4"));
        vecs.push_back(mk(1, 1, 1, 3,  10'h001, 1, 1, 0, "pre_tick1"));
        vecs.push_back(mk(1, 1, 1, 1,  10'h002, 1, 1, 0, "tick1"));
        vecs.push_back(mk(1, 1, 1, 4,  10'h004, 0, 1, 0, "tick2_buzz_off"));
        vecs.push_back(mk(1, 1, 1, 8,  10'h010, 1, 1, 0, "tick4_buzz_on"));
        vecs.push_back(mk(1, 1, 1, 4,  10'h020, 1, 1, 0, "tick5"));
        vecs.push_back(mk(1, 1, 1, 3,  10'h020, 1, 1, 0, "pre_timeout"));
        vecs.push_back(mk(1, 1, 1, 1,  10'h3FF, 0, 0, 1, "timeout"));
        vecs.push_back(mk(1, 1, 1, 10, 10'h3FF, 0, 0, 1, "timeout_steady"));
        vecs.push_back(mk(0, 1, 1, 4,  10'h3FF, 0, 0, 1, "timeout_alarm_low"));
        vecs.push_back(mk(1, 1, 1, 6,  10'h3FF, 0, 0, 1, "timeout_ignores_alarm"));
        vecs.push_back(mk(1, 0, 1, 3,  10'h3FF, 0, 0, 1, "timeout_ack_edge3"));
        vecs.push_back(mk(1, 0, 1, 1,  10'h000, 0, 0, 0, "timeout_ack_idle"));
        vecs.push_back(mk(0, 1, 1, 5,  10'h000, 0, 0, 0, "idle_rest"));
        // Ack coinciding with the sixth tick
        vecs.push_back(mk(1, 1, 1, 4,  10'h001, 1, 1, 0, "b_ring"));
        vecs.push_back(mk(1, 1, 1, 20, 10'h020, 1, 1, 0, "b_tick5"));
        vecs.push_back(mk(0, 0, 1, 3,  10'h020, 1, 1, 0, "b_pre_ack"));
        vecs.push_back(mk(0, 0, 1, 1,  10'h000, 0, 0, 0, "b_ack_beats_timeout"));
        vecs.push_back(mk(0, 1, 1, 4,  10'h000, 0, 0, 0, "b_idle"));
        // Retrigger at LED 008h
        vecs.push_back(mk(1, 1, 1, 4,  10'h001, 1, 1, 0, "c_ring"));
        vecs.push_back(mk(1, 1, 1, 12, 10'h008, 0, 1, 0, "c_led8"));
        vecs.push_back(mk(0, 1, 1, 2,  10'h008, 0, 1, 0, "c_alarm_low"));
        vecs.push_back(mk(1, 1, 1, 3,  10'h010, 1, 1, 0, "c_tick4"));
        vecs.push_back(mk(1, 1, 1, 1,  10'h001, 1, 1, 0, "c_retrigger"));
        vecs.push_back(mk(1, 1, 1, 3,  10'h001, 1, 1, 0, "c_pre_tick1"));
        vecs.push_back(mk(1, 1, 1, 1,  10'h002, 1, 1, 0, "c_tick1"));
        vecs.push_back(mk(1, 1, 1, 4,  10'h004, 0, 1, 0, "c_tick2"));
        vecs.push_back(mk(1, 1, 1, 4,  10'h008, 0, 1, 0, "c_tick3_no_timeout"));
        // Enable dropped mid-ring
        vecs.push_back(mk(1, 1, 0, 1,  10'h000, 0, 0, 0, "d_en_off_idle"));
        vecs.push_back(mk(1, 1, 1, 4,  10'h000, 0, 0, 0, "d_no_new_edge"));

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
        end

        // Asynchronous reset mid-ring, then a fresh alarm edge is required
        apply_vec(mk(0, 1, 1, 3, 10'h000, 0, 0, 0, "r_alarm_low"));
        apply_vec(mk(1, 1, 1, 4, 10'h001, 1, 1, 0, "r_ring"));
        @(posedge iCLK);
        #3;
        iRSTn = 1'b0;
        #1;
        push_exp(mk(1, 1, 1, 0, 10'h000, 0, 0, 0, "r_async_reset"));
        check_front();
        @(negedge iCLK);
        iRSTn = 1'b1;
        apply_vec(mk(1, 1, 1, 8, 10'h000, 0, 0, 0, "r_held_alarm_no_ring"));
        apply_vec(mk(0, 1, 1, 3, 10'h000, 0, 0, 0, "r_alarm_low_again"));
        apply_vec(mk(1, 1, 1, 3, 10'h000, 0, 0, 0, "r_new_edge3"));
        apply_vec(mk(1, 1, 1, 1, 10'h001, 1, 1, 0, "r_rering"));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
